// File: rtl/dlsc_pcie_s6_txbuf_pkg.sv
// Shared constants and elaboration helpers for the Spartan-6 PCIe TLP transmit buffer.
package dlsc_pcie_s6_txbuf_pkg;

    localparam int TXBUF_MODE_CUT = 0;
    localparam int TXBUF_MODE_SAF = 1;

    localparam int TXBUF_ADDR_MIN = 2;
    localparam int TXBUF_ADDR_MAX = 10;

    function automatic bit txbuf_addr_ok(input int addr);
        return (addr >= TXBUF_ADDR_MIN) && (addr <= TXBUF_ADDR_MAX);
    endfunction

    function automatic bit txbuf_mode_ok(input int mode);
        return (mode == TXBUF_MODE_CUT) || (mode == TXBUF_MODE_SAF);
    endfunction

    // Start threshold must be reachable, otherwise a cut-through TLP longer than the buffer never starts.
    function automatic bit txbuf_thresh_ok(input int addr, input int thresh);
        return (thresh >= 1) && (thresh <= (1 << addr));
    endfunction

endpackage

// File: rtl/dlsc_pcie_s6_txbuf_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read (maps to distributed RAM).
module dlsc_pcie_s6_txbuf_ram #(
    parameter int DATA = 33,
    parameter int ADDR = 4
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [ADDR-1:0] wr_addr,
    input  logic [DATA-1:0] wr_data,
    input  logic [ADDR-1:0] rd_addr,
    output logic [DATA-1:0] rd_data
);

    logic [DATA-1:0] mem [0:(1<<ADDR)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dlsc_pcie_s6_txbuf.sv
// Packet-aware TLP transmit buffer: cut-through with start threshold, or store-and-forward
// with a full-buffer escape for TLPs longer than the buffer.
module dlsc_pcie_s6_txbuf
    import dlsc_pcie_s6_txbuf_pkg::*;
#(
    parameter int DATA   = 32,
    parameter int ADDR   = 4,
    parameter int MODE   = TXBUF_MODE_CUT,
    parameter int THRESH = 3
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic            wr_ready,
    input  logic            wr_valid,
    input  logic            wr_last,
    input  logic [DATA-1:0] wr_data,
    output logic [ADDR:0]   wr_free,

    input  logic            rd_ready,
    output logic            rd_valid,
    output logic            rd_last,
    output logic [DATA-1:0] rd_data,
    output logic [ADDR:0]   rd_count,
    output logic [ADDR:0]   rd_pkts
);

    localparam int            D       = 1 << ADDR;
    localparam logic [ADDR:0] DEPTH   = (ADDR+1)'(D);
    localparam logic [ADDR:0] THR     = (ADDR+1)'(THRESH);
    localparam logic [ADDR:0] CNT_ONE = (ADDR+1)'(1);
    localparam logic [ADDR-1:0] PTR_ONE = ADDR'(1);

    if (!txbuf_addr_ok(ADDR)) begin : g_bad_addr
        $error("dlsc_pcie_s6_txbuf: ADDR must lie in 2..10");
    end
    if (!txbuf_mode_ok(MODE)) begin : g_bad_mode
        $error("dlsc_pcie_s6_txbuf: MODE must be cut-through or store-and-forward");
    end
    if (!txbuf_thresh_ok(ADDR, THRESH)) begin : g_bad_thresh
        $error("dlsc_pcie_s6_txbuf: THRESH must lie in 1..2**ADDR");
    end

    logic [ADDR-1:0] wr_ptr;
    logic [ADDR-1:0] rd_ptr;
    logic [ADDR:0]   count;
    logic [ADDR:0]   pkts;
    logic            rd_first;
    logic            wr_open;

    logic            push;
    logic            pop;
    logic            push_last;
    logic            pop_last;
    logic            start_ok;
    logic [DATA:0]   ram_rd;

    dlsc_pcie_s6_txbuf_ram #(
        .DATA (DATA+1),
        .ADDR (ADDR)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({wr_last, wr_data}),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd)
    );

    // wr_open keeps the write side closed during reset and until the first edge after release.
    assign wr_ready  = wr_open && (count != DEPTH);
    assign push      = wr_valid && wr_ready;
    assign push_last = push && wr_last;

    assign rd_last   = ram_rd[DATA];
    assign rd_data   = ram_rd[DATA-1:0];

    // Start conditions only grow while nothing is popped, so rd_valid holds once raised.
    always_comb begin
        start_ok = 1'b0;
        if (MODE == TXBUF_MODE_SAF) begin
            start_ok = (pkts != '0) || (count == DEPTH);
        end else begin
            start_ok = (count >= THR) || (pkts != '0);
        end
        rd_valid = rd_first ? start_ok : (count != '0);
    end

    assign pop      = rd_valid && rd_ready;
    assign pop_last = pop && rd_last;

    assign wr_free  = DEPTH - count;
    assign rd_count = count;
    assign rd_pkts  = pkts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_open  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pkts     <= '0;
            rd_first <= 1'b1;
        end else begin
            wr_open <= 1'b1;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                rd_first <= rd_last;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            case ({push_last, pop_last})
                2'b10:   pkts <= pkts + CNT_ONE;
                2'b01:   pkts <= pkts - CNT_ONE;
                default: pkts <= pkts;
            endcase
        end
    end

endmodule

// File: tb/tb_dlsc_pcie_s6_txbuf.sv
// Directed bench for dlsc_pcie_s6_txbuf across cut-through, store-and-forward, oversize and full/wrap setups.
`timescale 1ns/1ps
module tb_dlsc_pcie_s6_txbuf;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    int total = 0;
    int bad   = 0;

    int sent, got, low_ready, n_wr, n_rd, exp_cnt;
    bit seen_rise, acc_w, acc_r;

    // A: cut-through, D16, THRESH 3
    logic a_wr_valid, a_wr_last, a_rd_ready, a_wr_ready, a_rd_valid, a_rd_last;
    logic [31:0] a_wr_data, a_rd_data;
    logic [4:0]  a_wr_free, a_rd_count, a_rd_pkts;
    // B: store-and-forward, D16
    logic b_wr_valid, b_wr_last, b_rd_ready, b_wr_ready, b_rd_valid, b_rd_last;
    logic [31:0] b_wr_data, b_rd_data;
    logic [4:0]  b_wr_free, b_rd_count, b_rd_pkts;
    // C: store-and-forward, D4
    logic c_wr_valid, c_wr_last, c_rd_ready, c_wr_ready, c_rd_valid, c_rd_last;
    logic [31:0] c_wr_data, c_rd_data;
    logic [2:0]  c_wr_free, c_rd_count, c_rd_pkts;
    // F: cut-through, D8
    logic f_wr_valid, f_wr_last, f_rd_ready, f_wr_ready, f_rd_valid, f_rd_last;
    logic [31:0] f_wr_data, f_rd_data;
    logic [3:0]  f_wr_free, f_rd_count, f_rd_pkts;

    dlsc_pcie_s6_txbuf #(.DATA(32), .ADDR(4), .MODE(0), .THRESH(3)) u_a (
        .clk(clk), .rst_n(rst_n),
        .wr_ready(a_wr_ready), .wr_valid(a_wr_valid), .wr_last(a_wr_last), .wr_data(a_wr_data), .wr_free(a_wr_free),
        .rd_ready(a_rd_ready), .rd_valid(a_rd_valid), .rd_last(a_rd_last), .rd_data(a_rd_data),
        .rd_count(a_rd_count), .rd_pkts(a_rd_pkts));

    dlsc_pcie_s6_txbuf #(.DATA(32), .ADDR(4), .MODE(1), .THRESH(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .wr_ready(b_wr_ready), .wr_valid(b_wr_valid), .wr_last(b_wr_last), .wr_data(b_wr_data), .wr_free(b_wr_free),
        .rd_ready(b_rd_ready), .rd_valid(b_rd_valid), .rd_last(b_rd_last), .rd_data(b_rd_data),
        .rd_count(b_rd_count), .rd_pkts(b_rd_pkts));

    dlsc_pcie_s6_txbuf #(.DATA(32), .ADDR(2), .MODE(1), .THRESH(3)) u_c (
        .clk(clk), .rst_n(rst_n),
        .wr_ready(c_wr_ready), .wr_valid(c_wr_valid), .wr_last(c_wr_last), .wr_data(c_wr_data), .wr_free(c_wr_free),
        .rd_ready(c_rd_ready), .rd_valid(c_rd_valid), .rd_last(c_rd_last), .rd_data(c_rd_data),
        .rd_count(c_rd_count), .rd_pkts(c_rd_pkts));

    dlsc_pcie_s6_txbuf #(.DATA(32), .ADDR(3), .MODE(0), .THRESH(3)) u_f (
        .clk(clk), .rst_n(rst_n),
        .wr_ready(f_wr_ready), .wr_valid(f_wr_valid), .wr_last(f_wr_last), .wr_data(f_wr_data), .wr_free(f_wr_free),
        .rd_ready(f_rd_ready), .rd_valid(f_rd_valid), .rd_last(f_rd_last), .rd_data(f_rd_data),
        .rd_count(f_rd_count), .rd_pkts(f_rd_pkts));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected end before it", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_wr_valid = 0; a_wr_last = 0; a_wr_data = '0; a_rd_ready = 0;
        b_wr_valid = 0; b_wr_last = 0; b_wr_data = '0; b_rd_ready = 0;
        c_wr_valid = 0; c_wr_last = 0; c_wr_data = '0; c_rd_ready = 0;
        f_wr_valid = 0; f_wr_last = 0; f_wr_data = '0; f_rd_ready = 0;

        // reset values, before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wr_ready", 32'(a_wr_ready), 0);
        chk("rst_rd_valid", 32'(a_rd_valid), 0);
        chk("rst_wr_free",  32'(a_wr_free), 16);
        chk("rst_rd_count", 32'(a_rd_count), 0);
        chk("rst_rd_pkts",  32'(a_rd_pkts), 0);
        chk("rst_c_wr_free", 32'(c_wr_free), 4);
        tick; tick;
        rst_n = 1'b1;
        chk("rel_wr_ready_low", 32'(a_wr_ready), 0);
        tick;
        chk("rel_wr_ready_high", 32'(a_wr_ready), 1);
        chk("rel_f_wr_ready", 32'(f_wr_ready), 1);

        // cut-through: 6-beat TLP, rd_valid after 3rd push
        a_rd_ready = 1;
        for (int k = 0; k < 9; k++) begin
            if (k < 6) begin
                a_wr_valid = 1; a_wr_data = 32'hA0 + k; a_wr_last = (k == 5);
            end else begin
                a_wr_valid = 0; a_wr_last = 0;
            end
            tick;
            exp_cnt = ((k + 1 < 6) ? k + 1 : 6) - ((k > 2) ? k - 2 : 0);
            chk("ct_valid", 32'(a_rd_valid), 32'(k >= 2 && k <= 7));
            chk("ct_count", 32'(a_rd_count), exp_cnt);
            chk("ct_pkts",  32'(a_rd_pkts), 32'(k >= 5 && k <= 7));
            if (k >= 2 && k <= 7) begin
                chk("ct_data", a_rd_data, 32'hA0 + k - 2);
                chk("ct_last", 32'(a_rd_last), 32'(k == 7));
            end
        end
        chk("ct_free_end", 32'(a_wr_free), 16);

        // short TLP released before threshold
        a_wr_valid = 1; a_wr_data = 32'hB0; a_wr_last = 0;
        tick;
        chk("short_hold", 32'(a_rd_valid), 0);
        chk("short_count1", 32'(a_rd_count), 1);
        a_wr_data = 32'hB1; a_wr_last = 1;
        tick;
        a_wr_valid = 0; a_wr_last = 0;
        chk("short_valid", 32'(a_rd_valid), 1);
        chk("short_data0", a_rd_data, 32'hB0);
        chk("short_last0", 32'(a_rd_last), 0);
        chk("short_pkts1", 32'(a_rd_pkts), 1);
        chk("short_free", 32'(a_wr_free), 14);
        tick;
        chk("short_data1", a_rd_data, 32'hB1);
        chk("short_last1", 32'(a_rd_last), 1);
        chk("short_pkts_b", 32'(a_rd_pkts), 1);
        tick;
        chk("short_done", 32'(a_rd_valid), 0);
        chk("short_pkts0", 32'(a_rd_pkts), 0);

        // store-and-forward: 5 beats with 2 idle cycles between
        b_rd_ready = 1;
        for (int i = 0; i < 5; i++) begin
            b_wr_valid = 1; b_wr_data = 32'hC0 + i; b_wr_last = (i == 4);
            tick;
            b_wr_valid = 0; b_wr_last = 0;
            if (i < 4) begin
                chk("saf_hold", 32'(b_rd_valid), 0);
                chk("saf_count", 32'(b_rd_count), i + 1);
                tick;
                chk("saf_hold", 32'(b_rd_valid), 0);
                tick;
                chk("saf_hold", 32'(b_rd_valid), 0);
            end
        end
        chk("saf_pkts", 32'(b_rd_pkts), 1);
        for (int i = 0; i < 5; i++) begin
            chk("saf_valid", 32'(b_rd_valid), 1);
            chk("saf_data", b_rd_data, 32'hC0 + i);
            chk("saf_last", 32'(b_rd_last), 32'(i == 4));
            tick;
        end
        chk("saf_end_valid", 32'(b_rd_valid), 0);
        chk("saf_end_pkts", 32'(b_rd_pkts), 0);

        // oversize TLP in store-and-forward with D4
        c_rd_ready = 1;
        sent = 0; got = 0; low_ready = 0; seen_rise = 0;
        for (int cyc = 0; cyc < 30 && got < 7; cyc++) begin
            c_wr_valid = (sent < 7);
            c_wr_data  = 32'hD0 + sent;
            c_wr_last  = (sent == 6);
            acc_w = c_wr_valid && c_wr_ready;
            acc_r = c_rd_valid && c_rd_ready;
            if (c_rd_valid) begin
                if (!seen_rise) begin
                    chk("ovr_rise_count", 32'(c_rd_count), 4);
                    seen_rise = 1;
                end
                chk("ovr_data", c_rd_data, 32'hD0 + got);
                chk("ovr_last", 32'(c_rd_last), 32'(got == 6));
            end
            if (!c_wr_ready) low_ready++;
            tick;
            if (acc_w) sent++;
            if (acc_r) got++;
        end
        c_wr_valid = 0; c_wr_last = 0;
        chk("ovr_sent", sent, 7);
        chk("ovr_got", got, 7);
        chk("ovr_ready_low", low_ready, 1);
        chk("ovr_ready_end", 32'(c_wr_ready), 1);
        chk("ovr_pkts_end", 32'(c_rd_pkts), 0);

        // fill D8 then push and pop together across pointer wrap
        for (int i = 0; i < 8; i++) begin
            chk("fill_ready", 32'(f_wr_ready), 1);
            f_wr_valid = 1; f_wr_data = 32'hE0 + i; f_wr_last = (i % 4 == 3);
            tick;
        end
        f_wr_valid = 0; f_wr_last = 0;
        chk("full_ready", 32'(f_wr_ready), 0);
        chk("full_free", 32'(f_wr_free), 0);
        chk("full_count", 32'(f_rd_count), 8);
        chk("full_pkts", 32'(f_rd_pkts), 2);
        n_wr = 8; n_rd = 0;
        f_rd_ready = 1; f_wr_valid = 1;
        for (int c = 0; c < 20; c++) begin
            f_wr_data = 32'hE0 + n_wr;
            f_wr_last = (n_wr % 4 == 3);
            acc_w = f_wr_valid && f_wr_ready;
            acc_r = f_rd_valid && f_rd_ready;
            chk("wrap_valid", 32'(f_rd_valid), 1);
            chk("wrap_data", f_rd_data, 32'hE0 + n_rd);
            chk("wrap_last", 32'(f_rd_last), 32'(n_rd % 4 == 3));
            chk("wrap_count", 32'(f_rd_count), n_wr - n_rd);
            chk("wrap_band", 32'(f_rd_count >= 7 && f_rd_count <= 8), 1);
            chk("wrap_pkts", 32'(f_rd_pkts), n_wr / 4 - n_rd / 4);
            tick;
            if (acc_w) n_wr++;
            if (acc_r) n_rd++;
        end
        f_wr_valid = 0; f_wr_last = 0; f_rd_ready = 0;
        chk("wrap_pops", n_rd, 20);

        // reset after two beats of a 4-beat TLP have been read
        a_rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            a_wr_valid = 1; a_wr_data = 32'hF0 + i; a_wr_last = (i == 3);
            tick;
        end
        a_wr_valid = 0; a_wr_last = 0;
        chk("mid_data1", a_rd_data, 32'hF1);
        tick;
        chk("mid_data2", a_rd_data, 32'hF2);
        chk("mid_count", 32'(a_rd_count), 2);
        chk("mid_pkts", 32'(a_rd_pkts), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_ready", 32'(a_wr_ready), 0);
        chk("arst_rd_valid", 32'(a_rd_valid), 0);
        chk("arst_wr_free", 32'(a_wr_free), 16);
        chk("arst_rd_count", 32'(a_rd_count), 0);
        chk("arst_rd_pkts", 32'(a_rd_pkts), 0);
        tick;
        chk("arst_hold_ready", 32'(a_wr_ready), 0);
        rst_n = 1'b1;
        tick;
        chk("post_ready", 32'(a_wr_ready), 1);
        chk("post_valid", 32'(a_rd_valid), 0);
        a_wr_valid = 1; a_wr_data = 32'h77; a_wr_last = 1;
        tick;
        a_wr_valid = 0; a_wr_last = 0;
        chk("post_tlp_valid", 32'(a_rd_valid), 1);
        chk("post_tlp_data", a_rd_data, 32'h77);
        chk("post_tlp_last", 32'(a_rd_last), 1);
        chk("post_tlp_pkts", 32'(a_rd_pkts), 1);
        tick;
        chk("post_end_valid", 32'(a_rd_valid), 0);
        chk("post_end_count", 32'(a_rd_count), 0);
        chk("post_end_pkts", 32'(a_rd_pkts), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
